// File: rtl/entropy_conditioner.sv
// Conditions raw ring-oscillator bytes: warm-up discard, repetition-count health test,
// rotate-XOR folding of DECIM samples per byte, and a small valid/ready output FIFO.
module entropy_conditioner #(
    parameter int WARMUP     = 256,
    parameter int DECIM      = 8,
    parameter int RCT_LIMIT  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    output logic       src_en,
    input  logic [7:0] src_dat,
    output logic [7:0] out_dat,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       health_fail,
    input  logic       clear_fail,
    output logic [1:0] dbg_state
);
    // Output handshake: a byte transfers on every rising edge where out_valid and
    // out_ready are both high; out_valid never depends on out_ready.

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int WW = $clog2(WARMUP + 1);
    localparam int SW = $clog2(DECIM + 1);
    localparam int RW = $clog2(RCT_LIMIT + 1);

    localparam logic [WW-1:0] WARM_LAST = WW'(WARMUP - 1);
    localparam logic [SW-1:0] DEC_LAST  = SW'(DECIM - 1);
    localparam logic [RW-1:0] RCT_MAX   = RW'(RCT_LIMIT);
    localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_WARMUP, S_COLLECT, S_HOLD, S_FAIL} state_t;

    state_t        state;
    logic [WW-1:0] warm_cnt;
    logic [SW-1:0] samp_cnt;
    logic [RW-1:0] rep_cnt;
    logic [RW-1:0] rep_next;
    logic [7:0]    acc;
    logic [7:0]    prev;
    logic [7:0]    hold_reg;
    logic [7:0]    mixed;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          sample;
    logic          trip;
    logic          last;
    logic          full;
    logic          push_en;
    logic          pop_en;
    logic [7:0]    push_dat;

    assign mixed     = {acc[6:0], acc[7]} ^ src_dat;
    assign sample    = (state == S_COLLECT) && src_en;
    assign last      = (samp_cnt == DEC_LAST);
    assign full      = (count == FIFO_FULL);
    assign out_valid = (count != '0);
    assign out_dat   = out_valid ? mem[rd_ptr] : 8'h00;
    assign pop_en    = out_valid && out_ready;
    assign dbg_state = state;

    // rep_cnt==0 marks "no previous sample yet" so the first sample after warm-up starts at 1.
    always_comb begin
        rep_next = RW'(1);
        if (rep_cnt != '0 && src_dat == prev)
            rep_next = (rep_cnt == RCT_MAX) ? rep_cnt : rep_cnt + 1'b1;
        trip     = sample && (rep_next == RCT_MAX);
        push_en  = 1'b0;
        push_dat = mixed;
        if (sample && !trip && last && !full)
            push_en = 1'b1;
        if (state == S_HOLD && !full) begin
            push_en  = 1'b1;
            push_dat = hold_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_WARMUP;
            warm_cnt    <= '0;
            samp_cnt    <= '0;
            rep_cnt     <= '0;
            acc         <= 8'h00;
            prev        <= 8'h00;
            hold_reg    <= 8'h00;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            src_en      <= 1'b0;
            health_fail <= 1'b0;
        end else begin
            if (push_en) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_en)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push_en) - CW'(pop_en);

            case (state)
                S_WARMUP: begin
                    src_en  <= 1'b1;
                    rep_cnt <= '0;
                    if (src_en) begin
                        if (warm_cnt == WARM_LAST) begin
                            warm_cnt <= '0;
                            state    <= S_COLLECT;
                        end else begin
                            warm_cnt <= warm_cnt + 1'b1;
                        end
                    end
                end
                S_COLLECT: begin
                    if (sample) begin
                        if (trip) begin
                            // Tripping sample is dropped and the queue is flushed on the same edge.
                            state       <= S_FAIL;
                            src_en      <= 1'b0;
                            health_fail <= 1'b1;
                            acc         <= 8'h00;
                            samp_cnt    <= '0;
                            count       <= '0;
                            wr_ptr      <= '0;
                            rd_ptr      <= '0;
                        end else begin
                            prev    <= src_dat;
                            rep_cnt <= rep_next;
                            if (last) begin
                                acc      <= 8'h00;
                                samp_cnt <= '0;
                                if (full) begin
                                    hold_reg <= mixed;
                                    state    <= S_HOLD;
                                    src_en   <= 1'b0;
                                end
                            end else begin
                                acc      <= mixed;
                                samp_cnt <= samp_cnt + 1'b1;
                            end
                        end
                    end
                end
                S_HOLD: begin
                    if (!full) begin
                        state  <= S_COLLECT;
                        src_en <= 1'b1;
                    end
                end
                S_FAIL: begin
                    if (clear_fail) begin
                        state       <= S_WARMUP;
                        warm_cnt    <= '0;
                        health_fail <= 1'b0;
                        src_en      <= 1'b1;
                    end
                end
                default: state <= S_WARMUP;
            endcase
        end
    end
endmodule

// File: tb/tb_entropy_conditioner.sv
// Directed bench for entropy_conditioner: a queue-based reference model is compared every
// cycle, with literal expectations pinning the key scenarios.
module tb_entropy_conditioner;
    localparam int WARMUP     = 4;
    localparam int DECIM      = 2;
    localparam int RCT_LIMIT  = 4;
    localparam int FIFO_DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       src_en;
    logic [7:0] src_dat = 8'h00;
    logic [7:0] out_dat;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       health_fail;
    logic       clear_fail = 1'b0;
    logic [1:0] dbg_state;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    entropy_conditioner #(
        .WARMUP(WARMUP), .DECIM(DECIM), .RCT_LIMIT(RCT_LIMIT), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .src_en(src_en), .src_dat(src_dat),
        .out_dat(out_dat), .out_valid(out_valid), .out_ready(out_ready),
        .health_fail(health_fail), .clear_fail(clear_fail), .dbg_state(dbg_state)
    );

    // Reference model: FIFO contents as a queue, current byte's samples as a list.
    typedef enum {M_WARM, M_COLLECT, M_HOLD, M_FAIL} mmode_t;
    mmode_t     m_mode;
    int         m_warm;
    int         m_run;
    logic [7:0] m_prev;
    logic [7:0] m_hold;
    logic       m_en;
    logic       m_fail;
    logic [7:0] exp_q[$];
    logic [7:0] m_buf[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic       pop_ok, full, push, flush;
        logic [7:0] pv, acc;
        int         run;
        if (rst) begin
            m_mode = M_WARM; m_warm = 0; m_run = 0; m_prev = 0; m_hold = 0;
            m_en = 0; m_fail = 0; exp_q.delete(); m_buf.delete();
            return;
        end
        pop_ok = (exp_q.size() > 0) && out_ready;
        full   = (exp_q.size() == FIFO_DEPTH);
        push = 0; flush = 0; pv = 0;
        case (m_mode)
            M_WARM: begin
                if (m_en) begin
                    m_warm++;
                    if (m_warm == WARMUP) begin m_mode = M_COLLECT; m_warm = 0; m_run = 0; end
                end
                m_en = 1;
            end
            M_COLLECT: begin
                run = (m_run > 0 && src_dat == m_prev) ? m_run + 1 : 1;
                if (run >= RCT_LIMIT) begin
                    m_mode = M_FAIL; m_en = 0; m_fail = 1; flush = 1; m_buf.delete();
                end else begin
                    m_prev = src_dat; m_run = run; m_buf.push_back(src_dat);
                    if (m_buf.size() == DECIM) begin
                        acc = 8'h00;
                        foreach (m_buf[k]) acc = {acc[6:0], acc[7]} ^ m_buf[k];
                        m_buf.delete();
                        if (!full) begin push = 1; pv = acc; end
                        else begin m_hold = acc; m_mode = M_HOLD; m_en = 0; end
                    end
                end
            end
            M_HOLD: if (!full) begin push = 1; pv = m_hold; m_mode = M_COLLECT; m_en = 1; end
            M_FAIL: if (clear_fail) begin m_mode = M_WARM; m_warm = 0; m_fail = 0; m_en = 1; end
            default: ;
        endcase
        if (flush) exp_q.delete();
        else begin
            if (pop_ok) void'(exp_q.pop_front());
            if (push) exp_q.push_back(pv);
        end
    endtask

    always @(posedge clk) model_step();

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            check("src_en", src_en, m_en);
            check("health_fail", health_fail, m_fail);
            check("out_valid", out_valid, exp_q.size() > 0);
            check("out_dat", out_dat, (exp_q.size() > 0) ? exp_q[0] : 8'h00);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic start_from_reset(input logic [7:0] a, input logic [7:0] b, input logic [7:0] e);
        rst = 1'b1;
        tick();
        check("rst_src_en", src_en, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_dat", out_dat, 0);
        check("rst_health_fail", health_fail, 0);
        rst = 1'b0;
        src_dat = 8'hEE;
        repeat (5) tick();
        src_dat = a;
        tick();
        check("latency_early", out_valid, 0);
        src_dat = b;
        tick();
        check("first_valid", out_valid, 1);
        check("first_dat", out_dat, e);
    endtask

    initial begin
        logic [7:0] tbl [8];
        logic [7:0] drain [4];
        logic       reached;
        tbl   = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF1};
        drain = '{8'h10, 8'hD4, 8'h89, 8'h4C};

        // Reset, then first byte 0x81,0x02 -> 0x01 present for one cycle
        start_from_reset(8'h81, 8'h02, 8'h01);
        src_dat = 8'h5A;
        tick();
        check("one_cycle_valid", out_valid, 0);

        // Held 0x5A trips on its 4th sample and flushes the queued 0xEE
        out_ready = 1'b0;
        tick();
        check("fold_5a", out_dat, 8'hEE);
        tick();
        tick();
        check("trip_fail", health_fail, 1);
        check("trip_src_en", src_en, 0);
        check("trip_flush", out_valid, 0);
        repeat (3) tick();

        // clear_fail restarts warm-up; warm-up data is discarded
        clear_fail = 1'b1;
        tick();
        clear_fail = 1'b0;
        check("clear_fail_flag", health_fail, 0);
        check("clear_src_en", src_en, 1);
        src_dat   = 8'h77;
        out_ready = 1'b1;
        repeat (4) tick();
        src_dat = 8'h10;
        tick();
        src_dat = 8'h03;
        tick();
        check("rewarm_valid", out_valid, 1);
        check("rewarm_dat", out_dat, 8'h23);

        // Back-pressure: four queued, fifth held, one pop releases it
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            src_dat = tbl[i];
            tick();
        end
        check("hold_src_en", src_en, 0);
        check("hold_head", out_dat, 8'h23);
        repeat (2) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("pop_head", out_dat, 8'h10);
        check("hold_still_off", src_en, 0);
        tick();
        check("resume_src_en", src_en, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_order", out_dat, drain[i]);
            src_dat = 8'(8'h30 + i);
            tick();
        end

        // Reset mid-collect with three bytes queued
        out_ready = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 40 && !reached; i++) begin
            src_dat = 8'(8'h40 + i * 3);
            tick();
            if (exp_q.size() >= 3) reached = 1'b1;
        end
        check("fill_reached", reached, 1);
        src_dat = 8'h99;
        tick();
        start_from_reset(8'h81, 8'h02, 8'h01);

        // count=1 with simultaneous push and pop
        out_ready = 1'b0;
        src_dat = 8'h0F;
        tick();
        out_ready = 1'b1;
        src_dat = 8'hA0;
        tick();
        check("pushpop_valid", out_valid, 1);
        check("pushpop_dat", out_dat, 8'hBE);

        // Mixed traffic, clear_fail outside FAIL, then another trip and recovery
        for (int i = 0; i < 30; i++) begin
            out_ready  = (i % 3) != 0;
            clear_fail = (i == 5);
            src_dat    = 8'(i * 29 + 7);
            tick();
        end
        clear_fail = 1'b0;
        out_ready  = 1'b1;
        src_dat    = 8'hC3;
        repeat (8) tick();
        clear_fail = 1'b1;
        tick();
        clear_fail = 1'b0;
        for (int i = 0; i < 12; i++) begin
            src_dat = 8'(i * 53 + 1);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
